periph_bus_fabric: RTL and testbench

Parametrised data-side peripheral interconnect between the core's load/store port and N memory-mapped slaves (data memory, UART, I2C, QSPI, timer, USB, GPIO, instruction-memory write port). Unlike the fixed single-cycle bus it replaces, each slave may insert wait states through a ready handshake. Unmapped addresses and stalled slaves return an error response. A watchdog bounds every transaction.

---
 rtl/periph_bus_pkg.sv | 17 +
 rtl/periph_bus_decode.sv | 30 +++
 rtl/periph_bus_fabric.sv | 152 +++++++++++++++
 tb/tb_periph_bus_fabric.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_bus_pkg.sv
// rtl/periph_bus_pkg.sv - shared types and helpers for the peripheral bus fabric
package periph_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } bus_state_e;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    // Slot index width; a single-slot fabric still needs one index bit
    function automatic int slot_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/periph_bus_decode.sv
// rtl/periph_bus_decode.sv - slot-select field to one-hot slot, index and unmapped flag
module periph_bus_decode
    import periph_bus_pkg::*;
#(
    parameter int N_SLV   = 8,
    parameter int ADDR_W  = 15,
    parameter int SEL_LSB = 11,
    localparam int SEL_W  = ADDR_W - SEL_LSB,
    localparam int SLOT_W = slot_w(N_SLV)
) (
    input  logic [SEL_W-1:0]  sel_i,
    output logic [N_SLV-1:0]  slot_oh_o,
    output logic [SLOT_W-1:0] slot_idx_o,
    output logic              unmapped_o
);

    // Match the select field against every populated slot
    always_comb begin
        slot_oh_o  = '0;
        slot_idx_o = '0;
        for (int k = 0; k < N_SLV; k++) begin
            if (sel_i == SEL_W'(k)) begin
                slot_oh_o[k] = 1'b1;
                slot_idx_o   = SLOT_W'(k);
            end
        end
        unmapped_o = (32'(sel_i) >= 32'(N_SLV));
    end

endmodule

// File: rtl/periph_bus_fabric.sv
// rtl/periph_bus_fabric.sv - load/store port to N wait-state slaves with error and watchdog
module periph_bus_fabric
    import periph_bus_pkg::*;
#(
    parameter int          N_SLV     = 8,
    parameter int          ADDR_W    = 15,
    parameter int          SEL_LSB   = 11,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                data_req_i,
    input  logic                data_we_i,
    input  logic [3:0]          data_be_i,
    input  logic [ADDR_W-1:0]   data_addr_i,
    input  logic [31:0]         data_wdata_i,
    output logic                data_gnt_o,
    output logic                data_rvalid_o,
    output logic [31:0]         data_rdata_o,
    output logic                data_err_o,
    output logic [N_SLV-1:0]    slv_req_o,
    output logic                slv_we_o,
    output logic [3:0]          slv_be_o,
    output logic [SEL_LSB-1:0]  slv_addr_o,
    output logic [31:0]         slv_wdata_o,
    input  logic [N_SLV-1:0]    slv_ready_i,
    input  logic [N_SLV*32-1:0] slv_rdata_i
);

    localparam int SLOT_W = slot_w(N_SLV);
    localparam int WD_W   = $clog2(TIMEOUT + 1);

    bus_state_e        state_q, state_d;
    logic [N_SLV-1:0]  dec_oh, slot_oh_q;
    logic [SLOT_W-1:0] dec_idx, slot_q;
    logic              dec_unmapped;
    logic [WD_W-1:0]   wd_q;
    logic              ready_hit, wd_expired;
    logic [31:0]       rdata_sel;
    logic              accept, finish_ok, finish_abort;

    periph_bus_decode #(
        .N_SLV   (N_SLV),
        .ADDR_W  (ADDR_W),
        .SEL_LSB (SEL_LSB)
    ) u_decode (
        .sel_i      (data_addr_i[ADDR_W-1:SEL_LSB]),
        .slot_oh_o  (dec_oh),
        .slot_idx_o (dec_idx),
        .unmapped_o (dec_unmapped)
    );

    // Only the latched slot's ready counts; other slots' ready bits are noise
    assign ready_hit  = |(slv_ready_i & slot_oh_q);
    assign wd_expired = (wd_q == WD_W'(TIMEOUT));

    // Read data mux keyed by the latched slot index
    always_comb begin
        rdata_sel = '0;
        for (int k = 0; k < N_SLV; k++) begin
            if (slot_q == SLOT_W'(k)) begin
                rdata_sel = slv_rdata_i[32*k +: 32];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs; ready beats the watchdog on the same cycle
    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        finish_ok     = 1'b0;
        finish_abort  = 1'b0;
        data_gnt_o    = 1'b0;
        data_rvalid_o = 1'b0;
        slv_req_o     = '0;
        case (state_q)
            IDLE: begin
                data_gnt_o = !rst_i;
                if (data_req_i) begin
                    accept  = 1'b1;
                    state_d = dec_unmapped ? RESP : WAIT;
                end
            end
            WAIT: begin
                slv_req_o = slot_oh_q;
                if (ready_hit) begin
                    finish_ok = 1'b1;
                    state_d   = RESP;
                end else if (wd_expired) begin
                    finish_abort = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                data_rvalid_o = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture registers, watchdog and response data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slv_we_o     <= 1'b0;
            slv_be_o     <= '0;
            slv_addr_o   <= '0;
            slv_wdata_o  <= '0;
            slot_oh_q    <= '0;
            slot_q       <= '0;
            wd_q         <= '0;
            data_rdata_o <= '0;
            data_err_o   <= 1'b0;
        end else begin
            if (accept) begin
                slv_we_o    <= data_we_i;
                slv_be_o    <= data_be_i;
                slv_addr_o  <= data_addr_i[SEL_LSB-1:0];
                slv_wdata_o <= data_wdata_i;
                slot_oh_q   <= dec_oh;
                slot_q      <= dec_idx;
                wd_q        <= '0;
                if (dec_unmapped) begin
                    data_err_o   <= 1'b1;
                    data_rdata_o <= ERR_RDATA;
                end
            end
            if (state_q == WAIT && !ready_hit && !wd_expired) begin
                wd_q <= wd_q + WD_W'(1);
            end
            if (finish_ok) begin
                data_err_o   <= 1'b0;
                data_rdata_o <= slv_we_o ? 32'h0 : rdata_sel;
            end
            if (finish_abort) begin
                data_err_o   <= 1'b1;
                data_rdata_o <= ERR_RDATA;
            end
        end
    end

endmodule

// File: tb/tb_periph_bus_fabric.sv
// tb/tb_periph_bus_fabric.sv - self-checking bench for periph_bus_fabric
module tb_periph_bus_fabric;

    localparam int          N_SLV   = 6;
    localparam int          ADDR_W  = 15;
    localparam int          SEL_LSB = 11;
    localparam int          TIMEOUT = 15;
    localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;
    localparam int          NEVER   = 1000;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b1;
    logic                data_req_i = 1'b0;
    logic                data_we_i = 1'b0;
    logic [3:0]          data_be_i = '0;
    logic [ADDR_W-1:0]   data_addr_i = '0;
    logic [31:0]         data_wdata_i = '0;
    logic                data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0]         data_rdata_o;
    logic [N_SLV-1:0]    slv_req_o;
    logic                slv_we_o;
    logic [3:0]          slv_be_o;
    logic [SEL_LSB-1:0]  slv_addr_o;
    logic [31:0]         slv_wdata_o;
    logic [N_SLV-1:0]    slv_ready_i = '0;
    logic [N_SLV*32-1:0] slv_rdata_i = '0;

    int checks = 0;
    int failures = 0;

    periph_bus_fabric #(
        .N_SLV     (N_SLV),
        .ADDR_W    (ADDR_W),
        .SEL_LSB   (SEL_LSB),
        .TIMEOUT   (TIMEOUT),
        .ERR_RDATA (ERR_VAL)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .data_req_i    (data_req_i),
        .data_we_i     (data_we_i),
        .data_be_i     (data_be_i),
        .data_addr_i   (data_addr_i),
        .data_wdata_i  (data_wdata_i),
        .data_gnt_o    (data_gnt_o),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .data_err_o    (data_err_o),
        .slv_req_o     (slv_req_o),
        .slv_we_o      (slv_we_o),
        .slv_be_o      (slv_be_o),
        .slv_addr_o    (slv_addr_o),
        .slv_wdata_o   (slv_wdata_o),
        .slv_ready_i   (slv_ready_i),
        .slv_rdata_i   (slv_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        int          sel;
        int          off;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] sdata;
        int          exp_lat;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_reqc;
    } vec_t;

    typedef struct {
        int          lat;
        logic [31:0] rd;
        logic        err;
        int          reqc;
        logic        bad;
        logic        gnt;
        logic [31:0] hold_rd;
        logic        hold_err;
        logic        rv_after;
        logic        f_we;
        logic [3:0]  f_be;
        logic [31:0] f_addr;
        logic [31:0] f_wdata;
    } res_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Outcome of one access from the protocol rules alone
    function automatic void model(input logic we, input int sel, input int delay, input logic [31:0] sd,
                                  output int lat, output logic [31:0] rd, output logic err, output int reqc);
        if (sel >= N_SLV) begin
            lat = 1; rd = ERR_VAL; err = 1'b1; reqc = 0;
        end else if (delay <= TIMEOUT) begin
            lat = delay + 2; rd = we ? 32'h0 : sd; err = 1'b0; reqc = delay + 1;
        end else begin
            lat = TIMEOUT + 2; rd = ERR_VAL; err = 1'b1; reqc = TIMEOUT + 1;
        end
    endfunction

    // Issue one access at a negedge in IDLE; the selected slave answers after 'delay' wait cycles
    task automatic run_txn(input logic we, input logic [3:0] be, input int sel, input int off,
                           input logic [31:0] wdata, input int delay, input logic [31:0] sd, output res_t r);
        logic [N_SLV-1:0] exp_oh;
        logic [N_SLV-1:0] rdy;
        logic [ADDR_W-1:0] a;
        exp_oh = '0;
        if (sel < N_SLV) exp_oh[sel] = 1'b1;
        for (int k = 0; k < N_SLV; k++) slv_rdata_i[32*k +: 32] = $urandom;
        if (sel < N_SLV) slv_rdata_i[32*sel +: 32] = sd;
        a = {4'(sel), 11'(off)};
        data_req_i = 1'b1; data_we_i = we; data_be_i = be; data_addr_i = a; data_wdata_i = wdata;
        slv_ready_i = N_SLV'($urandom);
        r = '{default: '0};
        r.gnt = data_gnt_o;
        @(posedge clk_i); @(negedge clk_i);
        data_req_i = 1'b0; data_wdata_i = $urandom; data_addr_i = ADDR_W'($urandom);
        for (int n = 1; n <= 100; n++) begin
            if (data_rvalid_o) begin
                r.lat = n; r.rd = data_rdata_o; r.err = data_err_o;
                break;
            end
            if (slv_req_o != '0) r.reqc++;
            if (slv_req_o != exp_oh || data_gnt_o) r.bad = 1'b1;
            if (n == 1) begin
                r.f_we = slv_we_o; r.f_be = slv_be_o;
                r.f_addr = 32'(slv_addr_o); r.f_wdata = slv_wdata_o;
            end
            rdy = N_SLV'($urandom);
            if (sel < N_SLV) rdy[sel] = (n - 1 == delay);
            slv_ready_i = rdy;
            @(posedge clk_i); @(negedge clk_i);
        end
        slv_ready_i = N_SLV'($urandom);
        @(posedge clk_i); @(negedge clk_i);
        r.hold_rd = data_rdata_o; r.hold_err = data_err_o; r.rv_after = data_rvalid_o;
    endtask

    vec_t vecs[8];
    res_t r;
    int   m_lat, m_reqc;
    logic [31:0] m_rd;
    logic m_err;
    logic rv_seen;

    initial begin
        // we, be, sel, off, wdata, delay, slave data, lat, rdata, err, req cycles
        vecs[0] = '{1'b0, 4'hF, 1, 11'h010, 32'h0,         0,       32'h1234_5678, 2,  32'h1234_5678, 1'b0, 1};
        vecs[1] = '{1'b1, 4'h3, 5, 11'h7FC, 32'hCAFE_0001, 4,       32'h5555_AAAA, 6,  32'h0,         1'b0, 5};
        vecs[2] = '{1'b0, 4'hF, 7, 11'h004, 32'h0,         0,       32'h0,         1,  ERR_VAL,       1'b1, 0};
        vecs[3] = '{1'b0, 4'hF, 2, 11'h100, 32'h0,         NEVER,   32'h7777_0000, 17, ERR_VAL,       1'b1, 16};
        vecs[4] = '{1'b0, 4'hF, 2, 11'h104, 32'h0,         0,       32'h0BAD_F00D, 2,  32'h0BAD_F00D, 1'b0, 1};
        vecs[5] = '{1'b0, 4'hC, 3, 11'h3FF, 32'h0,         TIMEOUT, 32'hFEED_0003, 17, 32'hFEED_0003, 1'b0, 16};
        vecs[6] = '{1'b1, 4'h1, 15, 11'h000, 32'h1111_2222, 0,      32'h0,         1,  ERR_VAL,       1'b1, 0};
        vecs[7] = '{1'b0, 4'hF, 0, 11'h020, 32'h0,         TIMEOUT + 1, 32'h0,     17, ERR_VAL,       1'b1, 16};

        // Reset state
        repeat (2) @(negedge clk_i);
        check("rst_gnt", 32'(data_gnt_o), 32'h0);
        check("rst_rvalid", 32'(data_rvalid_o), 32'h0);
        check("rst_rdata", data_rdata_o, 32'h0);
        check("rst_err", 32'(data_err_o), 32'h0);
        check("rst_slv_req", 32'(slv_req_o), 32'h0);
        check("rst_slv_fields", {slv_wdata_o[15:0], 4'(slv_be_o), 1'(slv_we_o), 11'(slv_addr_o)}, 32'h0);
        rst_i = 1'b0;
        #1 check("gnt_after_release", 32'(data_gnt_o), 32'h1);
        @(negedge clk_i);

        // Directed table
        foreach (vecs[i]) begin
            run_txn(vecs[i].we, vecs[i].be, vecs[i].sel, vecs[i].off, vecs[i].wdata,
                    vecs[i].delay, vecs[i].sdata, r);
            check($sformatf("v%0d_gnt", i), 32'(r.gnt), 32'h1);
            check($sformatf("v%0d_latency", i), 32'(r.lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_rdata", i), r.rd, vecs[i].exp_rd);
            check($sformatf("v%0d_err", i), 32'(r.err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_req_cycles", i), 32'(r.reqc), 32'(vecs[i].exp_reqc));
            check($sformatf("v%0d_req_onehot", i), 32'(r.bad), 32'h0);
            check($sformatf("v%0d_rvalid_pulse", i), 32'(r.rv_after), 32'h0);
            check($sformatf("v%0d_rdata_hold", i), r.hold_rd, vecs[i].exp_rd);
            check($sformatf("v%0d_err_hold", i), 32'(r.hold_err), 32'(vecs[i].exp_err));
            if (vecs[i].exp_reqc > 0) begin
                check($sformatf("v%0d_slv_wdata", i), r.f_wdata, vecs[i].wdata);
                check($sformatf("v%0d_slv_addr", i), r.f_addr, 32'(vecs[i].off));
                check($sformatf("v%0d_slv_be_we", i), {27'h0, r.f_be, r.f_we}, {27'h0, vecs[i].be, vecs[i].we});
            end
        end

        // Randomised accesses against the reference model
        for (int t = 0; t < 40; t++) begin
            logic        we;
            int          sel, dly;
            logic [31:0] sd, wd;
            we  = 1'($urandom);
            sel = $urandom_range(0, 15);
            if (sel > 9) sel = sel % N_SLV;
            dly = ($urandom_range(0, 3) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 3) : $urandom_range(0, 5);
            sd  = $urandom;
            wd  = $urandom;
            model(we, sel, dly, sd, m_lat, m_rd, m_err, m_reqc);
            run_txn(we, 4'($urandom), sel, $urandom_range(0, 2047), wd, dly, sd, r);
            check($sformatf("r%0d_latency", t), 32'(r.lat), 32'(m_lat));
            check($sformatf("r%0d_rdata", t), r.rd, m_rd);
            check($sformatf("r%0d_err", t), 32'(r.err), 32'(m_err));
            check($sformatf("r%0d_req_cycles", t), 32'(r.reqc), 32'(m_reqc));
            check($sformatf("r%0d_req_onehot", t), 32'(r.bad), 32'h0);
            if (m_reqc > 0) check($sformatf("r%0d_slv_wdata", t), r.f_wdata, wd);
        end

        // Reset pulsed while a slave is stalling
        slv_ready_i = '0;
        data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'hF;
        data_addr_i = {4'd4, 11'h055}; data_wdata_i = 32'hABCD_1234;
        @(posedge clk_i); @(negedge clk_i);
        data_req_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("pre_reset_req", 32'(slv_req_o), 32'h10);
        rst_i = 1'b1;
        #1;
        check("reset_req_cleared", 32'(slv_req_o), 32'h0);
        check("reset_gnt_low", 32'(data_gnt_o), 32'h0);
        check("reset_wdata_cleared", slv_wdata_o, 32'h0);
        rv_seen = 1'b0;
        repeat (2) begin
            @(negedge clk_i);
            if (data_rvalid_o || data_gnt_o || slv_req_o != '0) rv_seen = 1'b1;
        end
        rst_i = 1'b0;
        #1 check("gnt_after_midreset", 32'(data_gnt_o), 32'h1);
        repeat (5) begin
            @(negedge clk_i);
            if (data_rvalid_o) rv_seen = 1'b1;
        end
        check("no_rvalid_after_abort", 32'(rv_seen), 32'h0);

        // Fabric still works afterwards
        run_txn(1'b0, 4'hF, 4, 11'h055, 32'h0, 1, 32'h4242_4242, r);
        check("post_reset_rdata", r.rd, 32'h4242_4242);
        check("post_reset_latency", 32'(r.lat), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
